// File: rtl/mux2_1_stream_arbiter.sv
// Two-input stream arbiter with bounded bursts feeding one registered output slot.
// A source keeps the grant for up to MAX_BURST beats while the other source is waiting.
module mux2_1_stream_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] i0_data,
   input  logic                  i0_valid,
   output logic                  i0_ready,
   input  logic [DATA_WIDTH-1:0] i1_data,
   input  logic                  i1_valid,
   output logic                  i1_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sel
);
   localparam int CW = $clog2(MAX_BURST + 1);

   logic [CW-1:0] cnt;
   logic          load_en;
   logic          own_v;
   logic          oth_v;
   logic          keep;
   logic          gnt_v;
   logic          gnt;
   logic          xfer;

   always_comb begin
      load_en  = !out_valid || out_ready;
      own_v    = sel ? i1_valid : i0_valid;
      oth_v    = sel ? i0_valid : i1_valid;
      keep     = own_v && (cnt < CW'(MAX_BURST));
      gnt_v    = own_v || oth_v;
      gnt      = sel;
      // Hand over once the owner is idle or exhausted; otherwise an exhausted owner restarts.
      if (!keep && oth_v) gnt = !sel;
      xfer     = gnt_v && load_en && !rst;
      i0_ready = xfer && !gnt;
      i1_ready = xfer && gnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         sel       <= 1'b0;
         cnt       <= '0;
      end else if (load_en) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= gnt ? i1_data : i0_data;
            sel      <= gnt;
            cnt      <= keep ? cnt + CW'(1) : CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_mux2_1_stream_arbiter.sv
// Self-checking bench: vector table, directed burst sequences and a random soak
// against a burst/queue reference model.
module tb_mux2_1_stream_arbiter;
   localparam int DW = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] i0_data = '0, i1_data = '0;
   logic          i0_valid = 1'b0, i1_valid = 1'b0, out_ready = 1'b0;
   logic          i0_ready, i1_ready, out_valid, sel;
   logic [DW-1:0] out_data;

   mux2_1_stream_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .i0_data(i0_data), .i0_valid(i0_valid), .i0_ready(i0_ready),
      .i1_data(i1_data), .i1_valid(i1_valid), .i1_ready(i1_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .sel(sel)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: who owns the current burst, how long it has run, and the held beat.
   int m_owner = 0, m_run = 0, m_od = 0;
   bit m_ov = 0;
   int q0[$], q1[$];
   int wt[2];

   typedef struct {
      bit r, v0; int d0; bit v1; int d1; bit ordy;
      bit e0r, e1r, eov; int eod; bit esel;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Owner continues while under the burst limit, else the other requester, else owner restarts.
   function automatic int pick(input bit v0, input bit v1, output bit cont);
      bit v[2];
      v[0] = v0; v[1] = v1;
      cont = v[m_owner] && (m_run < MB);
      if (cont) return m_owner;
      if (v[1 - m_owner]) return 1 - m_owner;
      if (v[m_owner]) return m_owner;
      return -1;
   endfunction

   // One clock: drive, check readys and consumed beat, clock, update model, check outputs.
   task automatic cycle(input bit r, input bit v0, input int d0, input bit v1, input int d1,
                        input bit ordy, output bit a0r, output bit a1r);
      int g, exp_d;
      bit ld, x, cont;
      bit v[2];
      v[0] = v0; v[1] = v1;
      rst = r; i0_valid = v0; i1_valid = v1; out_ready = ordy;
      i0_data = d0[DW-1:0]; i1_data = d1[DW-1:0];
      #1;
      ld = !m_ov || ordy;
      g = pick(v0, v1, cont);
      x = !r && ld && (g >= 0);
      a0r = i0_ready; a1r = i1_ready;
      chk("i0_ready", i0_ready, 32'(x && g == 0));
      chk("i1_ready", i1_ready, 32'(x && g == 1));
      if (!r && m_ov && ordy) begin
         if (m_owner == 0 && q0.size() > 0) exp_d = q0.pop_front();
         else if (m_owner == 1 && q1.size() > 0) exp_d = q1.pop_front();
         else exp_d = -1;
         chk("scoreboard", 32'(out_data), exp_d);
      end
      @(posedge clk);
      if (r) begin
         m_owner = 0; m_run = 0; m_ov = 0; m_od = 0;
         q0.delete(); q1.delete(); wt[0] = 0; wt[1] = 0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (x && g != s && v[s]) begin
               wt[s]++;
               chk("starvation", 32'(wt[s] <= MB + 1), 1);
            end else if (!v[s] || (x && g == s)) wt[s] = 0;
         end
         if (ld) begin
            m_ov = x;
            if (x) begin
               m_run = cont ? m_run + 1 : 1;
               m_owner = g;
               m_od = (g == 0) ? (d0 & 8'hff) : (d1 & 8'hff);
               if (g == 0) q0.push_back(m_od); else q1.push_back(m_od);
            end
         end
      end
      #1;
      chk("out_valid", out_valid, 32'(m_ov));
      chk("out_data", 32'(out_data), m_od);
      chk("sel", sel, m_owner);
   endtask

   initial begin
      bit a0, a1;
      int k0, k1, eg;

      tbl[0]  = '{1, 0, 'h00, 0, 'h00, 1, 0, 0, 0, 'h00, 0};
      tbl[1]  = '{0, 1, 'hA5, 0, 'h00, 1, 1, 0, 1, 'hA5, 0};
      tbl[2]  = '{0, 1, 'hA6, 0, 'h00, 0, 0, 0, 1, 'hA5, 0};
      tbl[3]  = '{0, 1, 'hA6, 0, 'h00, 0, 0, 0, 1, 'hA5, 0};
      tbl[4]  = '{0, 1, 'hA6, 0, 'h00, 0, 0, 0, 1, 'hA5, 0};
      tbl[5]  = '{0, 1, 'hA6, 0, 'h00, 1, 1, 0, 1, 'hA6, 0};
      tbl[6]  = '{0, 0, 'h00, 1, 'hB0, 1, 0, 1, 1, 'hB0, 1};
      tbl[7]  = '{0, 0, 'h00, 1, 'hB1, 1, 0, 1, 1, 'hB1, 1};
      tbl[8]  = '{1, 0, 'h00, 1, 'hB2, 1, 0, 0, 0, 'h00, 0};
      tbl[9]  = '{0, 1, 'hC0, 1, 'hC1, 1, 1, 0, 1, 'hC0, 0};
      tbl[10] = '{0, 0, 'h00, 0, 'h00, 1, 0, 0, 0, 'hC0, 0};
      tbl[11] = '{0, 0, 'h00, 0, 'h00, 0, 0, 0, 0, 'hC0, 0};

      @(posedge clk);
      #1;

      // Vector table: stall with held beat, handover on valid drop, reset mid-burst.
      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].r, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].ordy, a0, a1);
         chk($sformatf("tbl%0d_i0_ready", i), a0, 32'(tbl[i].e0r));
         chk($sformatf("tbl%0d_i1_ready", i), a1, 32'(tbl[i].e1r));
         chk($sformatf("tbl%0d_out_valid", i), out_valid, 32'(tbl[i].eov));
         chk($sformatf("tbl%0d_out_data", i), 32'(out_data), tbl[i].eod);
         chk($sformatf("tbl%0d_sel", i), sel, 32'(tbl[i].esel));
      end

      // Both sources saturated: 4 beats each, alternating, no bubbles.
      cycle(1, 0, 0, 0, 0, 1, a0, a1);
      k0 = 0; k1 = 0;
      for (int i = 0; i < 16; i++) begin
         eg = (i / MB) % 2;
         cycle(0, 1, 'h10 + k0, 1, 'h20 + k1, 1, a0, a1);
         chk("alt_sel", sel, eg);
         chk("alt_out_valid", out_valid, 1);
         chk("alt_out_data", 32'(out_data), eg ? 'h20 + k1 : 'h10 + k0);
         if (eg == 0) k0++; else k1++;
      end

      // Only i1 requesting: burst restarts keep it flowing every cycle.
      cycle(1, 0, 0, 0, 0, 1, a0, a1);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, 0, 1, 'h30 + i, 1, a0, a1);
         chk("solo_i1_ready", a1, 1);
         chk("solo_out_valid", out_valid, 1);
         chk("solo_out_data", 32'(out_data), 'h30 + i);
      end

      // Random soak with occasional reset pulses.
      cycle(1, 0, 0, 0, 0, 1, a0, a1);
      for (int i = 0; i < 10000; i++) begin
         cycle($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 255),
               $urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 3) != 0, a0, a1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mux2_1_stream_arbiter.md
MUX2_1_STREAM_ARBITER -- requirements
Module: mux2_1_stream_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of every data path.
REQ-002 Parameter MAX_BURST, default 4, legal range 1..255, SHALL set the maximum number of consecutive beats granted to one source while the other is requesting.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 i0_data  input  DATA_WIDTH  SHALL be the source-0 payload.
REQ-007 i0_valid  input  1  SHALL indicate that i0_data is valid.
REQ-008 i0_ready  output  1  SHALL indicate that the block accepts i0_data this cycle.
REQ-009 i1_data, i1_valid, i1_ready SHALL be the source-1 equivalents of REQ-006..REQ-008.
REQ-010 out_data  output  DATA_WIDTH  SHALL be the registered selected payload.
REQ-011 out_valid  output  1  SHALL indicate that out_data holds an unconsumed beat.
REQ-012 out_ready  input  1  SHALL indicate that the downstream consumes out_data this cycle.
REQ-013 sel  output  1  SHALL be the registered source of the most recent accepted beat (0 = i0, 1 = i1).

Function
REQ-014 Transfer rule on every port: a beat moves only in a cycle where valid and ready are both high at the rising edge.
REQ-015 load_en SHALL be (!out_valid || out_ready); no input SHALL be accepted when load_en is low.
REQ-016 Internal counter cnt, width ceil(log2(MAX_BURST+1)), SHALL count beats accepted from source sel in the current burst.
REQ-017 The grant g SHALL be decided combinationally in this priority order: (a) g = sel if i[sel]_valid and cnt < MAX_BURST; (b) else g = !sel if i[!sel]_valid; (c) else g = sel if i[sel]_valid (burst restart); (d) else no grant.
REQ-018 i[g]_ready SHALL equal load_en; the non-granted ready SHALL be 0; with no grant both readys SHALL be 0.
REQ-019 Readys SHALL NOT depend combinationally on their own valid, apart from the grant selection in REQ-017.
REQ-020 On a transfer, the block SHALL perform all of the following at the edge: out_data <= i[g]_data; out_valid <= 1; sel <= g; cnt <= cnt+1 in case (a), otherwise cnt <= 1.
REQ-021 When load_en is high and no transfer occurs, out_valid SHALL go to 0, and out_data, sel and cnt SHALL hold.
REQ-022 When load_en is low, out_data, out_valid, sel and cnt SHALL hold; out_data SHALL be stable while out_valid && !out_ready.
REQ-023 Latency SHALL be exactly 1 cycle from input transfer to out_valid; with out_ready held high, throughput SHALL be 1 beat per cycle with no bubbles, including at burst switches and restarts.
REQ-024 If the owning source drops valid mid-burst, the other source's request SHALL win the next cycle (case b); if neither requests, cnt SHALL hold and the owner resumes under case (a).
REQ-025 Simultaneous output consume and input accept in one cycle SHALL keep out_valid at 1 and load the new beat.

Reset
REQ-026 While rst is high at an edge: out_valid <= 0, out_data <= 0, sel <= 0, cnt <= 0; both readys SHALL be 0 during any cycle in which rst is high.
REQ-027 Reset asserted mid-burst or mid-stall SHALL discard the held beat; the first grant after reset SHALL favour i0 under REQ-017.

Verification
REQ-028 Inputs: MAX_BURST=4, both valids held high, i0_data=0x10.., i1_data=0x20.., out_ready=1 -> output shows 4 i0 beats, then 4 i1 beats, alternating; sel toggles every 4 cycles; no bubble.
REQ-029 Inputs: only i1 is valid for 10 beats -> 10 consecutive i1 beats are accepted; cnt restarts at 1 after every 4th beat; out_valid stays high throughout.
REQ-030 Inputs: i0 beat 0xA5 is accepted, then out_ready=0 for 3 cycles -> out_data stays 0xA5 with out_valid=1, and both readys are 0; on out_ready=1, the next pending beat loads in the same cycle.
REQ-031 Inputs: i0 bursts 2 beats, then drops valid while i1 is valid -> i1 is granted the next cycle and sel becomes 1.
REQ-032 Inputs: rst is pulsed for 1 cycle during an i1 burst with out_valid=1 -> at the next edge out_valid=0, sel=0, cnt=0, and out_data=0.
REQ-033 Inputs: a random valid/ready soak of 10k cycles -> a scoreboard sees every accepted beat exactly once, in per-source order, and no source waits more than MAX_BURST+1 transfers.
